// File: rtl/cordic_rot_if.sv
// cordic_rot_if: angle-in / cos,sin-out valid-ready bundle for cordic_rot
interface cordic_rot_if;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] angle;
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] cos_out;
    logic signed [31:0] sin_out;
    logic               busy;
    modport master (
        output in_valid, angle, out_ready,
        input  in_ready, out_valid, cos_out, sin_out, busy
    );
    modport slave (
        input  in_valid, angle, out_ready,
        output in_ready, out_valid, cos_out, sin_out, busy
    );
endinterface

// File: rtl/cordic_rot.sv
// cordic_rot: iterative rotation-mode CORDIC, Q16 degrees in, Q16 cos/sin out, one micro-rotation per clock.
// Option: define CORDIC_GAIN_COMP_EN to pre-scale by 1/K so outputs are unit amplitude;
// without it outputs carry the CORDIC gain (~1.64676) and the caller compensates.
module cordic_rot #(
    parameter int STG  = 16,
    parameter int FRAC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    cordic_rot_if.slave bus
);
    localparam logic signed [31:0] DEG90  = 32'sd90 <<< FRAC;
    localparam logic signed [31:0] DEG180 = 32'sd180 <<< FRAC;
`ifdef CORDIC_GAIN_COMP_EN
    localparam logic signed [31:0] K0 = 32'sd39796;
`else
    localparam logic signed [31:0] K0 = 32'sd1 <<< FRAC;
`endif
    localparam logic [3:0] LAST = 4'(STG - 1);
    localparam logic signed [31:0] ATAN [16] = '{
        32'sd2949120, 32'sd1740992, 32'sd919872, 32'sd466944,
        32'sd234368,  32'sd117312,  32'sd58688,  32'sd29312,
        32'sd14656,   32'sd7360,    32'sd3648,   32'sd1856,
        32'sd896,     32'sd448,     32'sd256,    32'sd128
    };

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic signed [31:0] x, y, z;
    logic [3:0]         count;
    logic signed [31:0] a_cl, x0, z0, x_nxt, y_nxt, z_nxt;
    logic               d_pos;

    assign bus.in_ready = (state == IDLE);
    assign bus.busy     = (state != IDLE);

    // Accept path: clamp to +/-180 deg, fold outer half-plane onto |z|<=90 by negating X0
    always_comb begin
        a_cl = bus.angle > DEG180 ? DEG180 : (bus.angle < -DEG180 ? -DEG180 : bus.angle);
        z0   = a_cl > DEG90 ? a_cl - DEG180 : (a_cl < -DEG90 ? a_cl + DEG180 : a_cl);
        x0   = (a_cl > DEG90 || a_cl < -DEG90) ? -K0 : K0;
    end

    // One micro-rotation, direction chosen by the sign of the residual angle
    always_comb begin
        d_pos = ~z[31];
        x_nxt = d_pos ? x - (y >>> count) : x + (y >>> count);
        y_nxt = d_pos ? y + (x >>> count) : y - (x >>> count);
        z_nxt = d_pos ? z - ATAN[count] : z + ATAN[count];
    end

    // Control FSM and datapath registers; result latched on the last iteration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            x             <= '0;
            y             <= '0;
            z             <= '0;
            count         <= '0;
            bus.out_valid <= 1'b0;
            bus.cos_out   <= '0;
            bus.sin_out   <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    x     <= x0;
                    y     <= '0;
                    z     <= z0;
                    count <= '0;
                    state <= RUN;
                end
                RUN: begin
                    x     <= x_nxt;
                    y     <= y_nxt;
                    z     <= z_nxt;
                    count <= count + 4'd1;
                    if (count == LAST) begin
                        bus.cos_out   <= x_nxt;
                        bus.sin_out   <= y_nxt;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
